// File: rtl/proc_run_ctrl_if.sv
// Control/status bundle between a host and the processor run controller.
// The host drives run requests and halt indications; the controller drives core resets, enables and status.
interface proc_run_ctrl_if #(
   parameter int N_CORES = 1,
   parameter int CNT_W   = 32
);
   logic               start;
   logic               abort;
   logic               step_mode;
   logic               step;
   logic [CNT_W-1:0]   max_cycles;
   logic [N_CORES-1:0] core_halt;
   logic [N_CORES-1:0] core_reset;
   logic [N_CORES-1:0] core_en;
   logic               busy;
   logic               done;
   logic               timeout;
   logic [N_CORES-1:0] halted;
   logic [CNT_W-1:0]   cycle_count;

   modport master (
      output start, abort, step_mode, step, max_cycles, core_halt,
      input  core_reset, core_en, busy, done, timeout, halted, cycle_count
   );

   modport slave (
      input  start, abort, step_mode, step, max_cycles, core_halt,
      output core_reset, core_en, busy, done, timeout, halted, cycle_count
   );
endinterface

// File: rtl/proc_run_ctrl.sv
// Run controller for MIPS cores: stretched reset, cycle budget, per-core halt tracking,
// single-step and abort. All outputs are registered.
module proc_run_ctrl #(
   parameter int N_CORES    = 1,
   parameter int RST_CYCLES = 2,
   parameter int CNT_W      = 32
) (
   input  logic            ref_clk,
   input  logic            reset,
   proc_run_ctrl_if.slave  bus
);

   localparam int HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, RST_HOLD, RUN, DONE} state_t;

   state_t             state;
   logic [HOLD_W-1:0]  hold_cnt;
   logic               step_mode_q;
   logic [CNT_W-1:0]   max_q;
   logic [N_CORES-1:0] core_reset_q;
   logic [N_CORES-1:0] core_en_q;
   logic [N_CORES-1:0] halted_q;
   logic               busy_q;
   logic               done_q;
   logic               timeout_q;
   logic [CNT_W-1:0]   count_q;

   logic               any_en;
   logic               step_grant;
   logic               budget_hit;
   logic [N_CORES-1:0] halted_upd;
   logic [N_CORES-1:0] en_next;
   logic [CNT_W-1:0]   count_upd;

   // Bookkeeping for the cycle that is currently enabled; a step arriving while
   // a granted cycle is still in flight is dropped rather than queued.
   always_comb begin
      any_en     = |core_en_q;
      halted_upd = halted_q | (core_en_q & bus.core_halt);
      count_upd  = count_q;
      if (any_en && (count_q != '1)) begin
         count_upd = count_q + 1'b1;
      end
      budget_hit = any_en && (max_q != '0) && (count_upd == max_q);
      step_grant = bus.step && !any_en;
      en_next    = (!step_mode_q || step_grant) ? ~halted_upd : '0;
   end

   always_ff @(posedge ref_clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         hold_cnt     <= '0;
         step_mode_q  <= 1'b0;
         max_q        <= '0;
         core_reset_q <= '1;
         core_en_q    <= '0;
         halted_q     <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         timeout_q    <= 1'b0;
         count_q      <= '0;
      end else if (bus.abort) begin
         // cycle_count and halted stay visible until the next start
         state        <= IDLE;
         hold_cnt     <= '0;
         core_reset_q <= '1;
         core_en_q    <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         timeout_q    <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (bus.start) begin
                  state        <= RST_HOLD;
                  hold_cnt     <= '0;
                  step_mode_q  <= bus.step_mode;
                  max_q        <= bus.max_cycles;
                  core_reset_q <= '1;
                  core_en_q    <= '0;
                  halted_q     <= '0;
                  busy_q       <= 1'b1;
                  done_q       <= 1'b0;
                  timeout_q    <= 1'b0;
                  count_q      <= '0;
               end
            end
            RST_HOLD: begin
               if (hold_cnt == HOLD_LAST) begin
                  state        <= RUN;
                  core_reset_q <= '0;
                  core_en_q    <= en_next;
               end else begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
            RUN: begin
               halted_q <= halted_upd;
               count_q  <= count_upd;
               // A halt that completes the set beats budget exhaustion on the same cycle
               if (&halted_upd) begin
                  state     <= DONE;
                  core_en_q <= '0;
                  busy_q    <= 1'b0;
                  done_q    <= 1'b1;
                  timeout_q <= 1'b0;
               end else if (budget_hit) begin
                  state     <= DONE;
                  core_en_q <= '0;
                  busy_q    <= 1'b0;
                  done_q    <= 1'b1;
                  timeout_q <= 1'b1;
               end else begin
                  core_en_q <= en_next;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.core_reset  = core_reset_q;
   assign bus.core_en     = core_en_q;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.timeout     = timeout_q;
   assign bus.halted      = halted_q;
   assign bus.cycle_count = count_q;

endmodule

// File: tb/tb_proc_run_ctrl.sv
// Self-checking bench for proc_run_ctrl: a per-cycle vector table plus directed
// sequences for budget timeout, staggered halts, stepping, abort, saturation and async reset.
module tb_proc_run_ctrl;

   logic ref_clk;
   logic reset;

   int checks   = 0;
   int failures = 0;

   proc_run_ctrl_if #(.N_CORES(2), .CNT_W(32)) m_bus ();
   proc_run_ctrl_if #(.N_CORES(1), .CNT_W(4))  s_bus ();

   proc_run_ctrl #(.N_CORES(2), .RST_CYCLES(2), .CNT_W(32)) u_main (
      .ref_clk (ref_clk),
      .reset   (reset),
      .bus     (m_bus)
   );

   proc_run_ctrl #(.N_CORES(1), .RST_CYCLES(2), .CNT_W(4)) u_sat (
      .ref_clk (ref_clk),
      .reset   (reset),
      .bus     (s_bus)
   );

   initial ref_clk = 1'b0;
   always #5 ref_clk = ~ref_clk;

   typedef struct {
      logic        start;
      logic        abort;
      logic        step_mode;
      logic        step;
      logic [31:0] max_cycles;
      logic [1:0]  core_halt;
      logic [1:0]  exp_reset;
      logic [1:0]  exp_en;
      logic        exp_busy;
      logic        exp_done;
      logic        exp_timeout;
      logic [1:0]  exp_halted;
      logic [31:0] exp_count;
   } vec_t;

   vec_t tbl[13];

   function automatic vec_t mk(logic st, logic ab, logic sm, logic sp, logic [31:0] mx,
                               logic [1:0] hl, logic [1:0] er, logic [1:0] ee, logic eb,
                               logic ed, logic et, logic [1:0] eh, logic [31:0] ec);
      vec_t v;
      v.start = st; v.abort = ab; v.step_mode = sm; v.step = sp; v.max_cycles = mx;
      v.core_halt = hl; v.exp_reset = er; v.exp_en = ee; v.exp_busy = eb;
      v.exp_done = ed; v.exp_timeout = et; v.exp_halted = eh; v.exp_count = ec;
      return v;
   endfunction

   task automatic tick();
      @(posedge ref_clk);
      @(negedge ref_clk);
   endtask

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] expected);
      checks++;
      if (act !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, expected);
      end
   endtask

   task automatic apply_stimulus(input int idx, input vec_t v);
      m_bus.start      = v.start;
      m_bus.abort      = v.abort;
      m_bus.step_mode  = v.step_mode;
      m_bus.step       = v.step;
      m_bus.max_cycles = v.max_cycles;
      m_bus.core_halt  = v.core_halt;
      tick();
      check_output($sformatf("vec%0d.core_reset", idx), 32'(m_bus.core_reset), 32'(v.exp_reset));
      check_output($sformatf("vec%0d.core_en", idx), 32'(m_bus.core_en), 32'(v.exp_en));
      check_output($sformatf("vec%0d.busy", idx), 32'(m_bus.busy), 32'(v.exp_busy));
      check_output($sformatf("vec%0d.done", idx), 32'(m_bus.done), 32'(v.exp_done));
      check_output($sformatf("vec%0d.timeout", idx), 32'(m_bus.timeout), 32'(v.exp_timeout));
      check_output($sformatf("vec%0d.halted", idx), 32'(m_bus.halted), 32'(v.exp_halted));
      check_output($sformatf("vec%0d.cycle_count", idx), m_bus.cycle_count, v.exp_count);
   endtask

   task automatic start_run(input logic sm, input logic [31:0] mx);
      m_bus.start      = 1'b1;
      m_bus.step_mode  = sm;
      m_bus.max_cycles = mx;
      tick();
      m_bus.start      = 1'b0;
      m_bus.step_mode  = 1'b0;
      m_bus.max_cycles = '0;
   endtask

   // Runs the main controller until done, raising each lane's halt on the
   // given enabled-cycle index (0 = never) and tallying what it observes.
   task automatic run_main(input int halt0, input int halt1, input int budget,
                           output int en_cycles, output int en0_cycles, output int rst_cycles,
                           output logic [1:0] halted_mid, output bit finished);
      en_cycles = 0; en0_cycles = 0; rst_cycles = 0; halted_mid = '0; finished = 0;
      for (int c = 0; c < budget; c++) begin
         if (m_bus.done) begin
            finished = 1;
            break;
         end
         if (m_bus.busy && (m_bus.core_reset == 2'b11)) rst_cycles++;
         m_bus.core_halt = '0;
         if (m_bus.core_en != '0) begin
            en_cycles++;
            if (m_bus.core_en[0]) en0_cycles++;
            if (en_cycles == halt0) m_bus.core_halt[0] = 1'b1;
            if (en_cycles == halt1) m_bus.core_halt[1] = 1'b1;
            if (en_cycles == halt0 + 1) halted_mid = m_bus.halted;
         end
         tick();
      end
      m_bus.core_halt = '0;
   endtask

   initial begin
      int en_cycles, en0_cycles, rst_cycles, steps_seen;
      logic [1:0] halted_mid;
      bit finished;
      bit reached;

      reset = 1'b0;
      m_bus.start = 1'b0; m_bus.abort = 1'b0; m_bus.step_mode = 1'b0; m_bus.step = 1'b0;
      m_bus.max_cycles = '0; m_bus.core_halt = '0;
      s_bus.start = 1'b0; s_bus.abort = 1'b0; s_bus.step_mode = 1'b0; s_bus.step = 1'b0;
      s_bus.max_cycles = '0; s_bus.core_halt = '0;

      tick(); tick();
      check_output("rst.core_reset", 32'(m_bus.core_reset), 32'h3);
      check_output("rst.core_en", 32'(m_bus.core_en), 32'h0);
      check_output("rst.busy", 32'(m_bus.busy), 32'h0);
      check_output("rst.done", 32'(m_bus.done), 32'h0);
      check_output("rst.cycle_count", m_bus.cycle_count, 32'h0);
      reset = 1'b1;
      tick();

      // Per-cycle table: budget=3 run, restart from DONE with staggered halts, abort in DONE
      tbl[0]  = mk(1,0,0,0,3, 2'b00, 2'b11,2'b00,1,0,0,2'b00,0);
      tbl[1]  = mk(0,0,0,0,0, 2'b00, 2'b11,2'b00,1,0,0,2'b00,0);
      tbl[2]  = mk(0,0,0,0,0, 2'b00, 2'b00,2'b11,1,0,0,2'b00,0);
      tbl[3]  = mk(0,0,0,0,0, 2'b00, 2'b00,2'b11,1,0,0,2'b00,1);
      tbl[4]  = mk(0,0,0,0,0, 2'b00, 2'b00,2'b11,1,0,0,2'b00,2);
      tbl[5]  = mk(0,0,0,0,0, 2'b00, 2'b00,2'b00,0,1,1,2'b00,3);
      tbl[6]  = mk(1,0,0,0,0, 2'b00, 2'b11,2'b00,1,0,0,2'b00,0);
      tbl[7]  = mk(1,0,0,0,0, 2'b00, 2'b11,2'b00,1,0,0,2'b00,0);
      tbl[8]  = mk(0,0,0,0,0, 2'b00, 2'b00,2'b11,1,0,0,2'b00,0);
      tbl[9]  = mk(0,0,0,0,0, 2'b01, 2'b00,2'b10,1,0,0,2'b01,1);
      tbl[10] = mk(0,0,0,0,0, 2'b11, 2'b00,2'b00,0,1,0,2'b11,2);
      tbl[11] = mk(0,1,0,0,0, 2'b00, 2'b11,2'b00,0,0,0,2'b11,2);
      tbl[12] = mk(0,0,0,0,0, 2'b00, 2'b11,2'b00,0,0,0,2'b11,2);
      for (int i = 0; i < 13; i++) apply_stimulus(i, tbl[i]);
      m_bus.abort = 1'b0;

      // Budget timeout with no halts
      start_run(1'b0, 32'd36);
      run_main(0, 0, 100, en_cycles, en0_cycles, rst_cycles, halted_mid, finished);
      check_output("t1.finished", 32'(finished), 32'd1);
      check_output("t1.rst_cycles", 32'(rst_cycles), 32'd2);
      check_output("t1.en_cycles", 32'(en_cycles), 32'd36);
      check_output("t1.timeout", 32'(m_bus.timeout), 32'd1);
      check_output("t1.cycle_count", m_bus.cycle_count, 32'd36);
      check_output("t1.core_reset", 32'(m_bus.core_reset), 32'd0);

      // Staggered halts, unlimited budget
      start_run(1'b0, 32'd0);
      run_main(5, 9, 100, en_cycles, en0_cycles, rst_cycles, halted_mid, finished);
      check_output("t2.finished", 32'(finished), 32'd1);
      check_output("t2.halted_mid", 32'(halted_mid), 32'h1);
      check_output("t2.en0_cycles", 32'(en0_cycles), 32'd5);
      check_output("t2.halted", 32'(m_bus.halted), 32'h3);
      check_output("t2.timeout", 32'(m_bus.timeout), 32'd0);
      check_output("t2.cycle_count", m_bus.cycle_count, 32'd9);

      // Halt and budget on the same cycle
      start_run(1'b0, 32'd10);
      run_main(10, 10, 100, en_cycles, en0_cycles, rst_cycles, halted_mid, finished);
      check_output("t4.finished", 32'(finished), 32'd1);
      check_output("t4.done", 32'(m_bus.done), 32'd1);
      check_output("t4.timeout", 32'(m_bus.timeout), 32'd0);
      check_output("t4.cycle_count", m_bus.cycle_count, 32'd10);

      // Single-step: three spaced pulses, then a held step that must not queue
      start_run(1'b1, 32'd0);
      tick(); tick(); tick();
      check_output("t3.idle_en", 32'(m_bus.core_en), 32'h0);
      steps_seen = 0;
      for (int p = 0; p < 3; p++) begin
         m_bus.step = 1'b1;
         tick();
         m_bus.step = 1'b0;
         check_output($sformatf("t3.grant%0d", p), 32'(m_bus.core_en), 32'h3);
         if (m_bus.core_en != '0) steps_seen++;
         tick();
         check_output($sformatf("t3.drop%0d", p), 32'(m_bus.core_en), 32'h0);
         tick(); tick();
      end
      check_output("t3.cycle_count", m_bus.cycle_count, 32'(steps_seen));
      check_output("t3.busy", 32'(m_bus.busy), 32'd1);
      check_output("t3.done", 32'(m_bus.done), 32'd0);
      m_bus.step = 1'b1;
      tick();
      tick();
      check_output("t3.no_queue_en", 32'(m_bus.core_en), 32'h0);
      m_bus.step = 1'b0;
      tick();
      check_output("t3.no_queue_count", m_bus.cycle_count, 32'd4);
      m_bus.abort = 1'b1;
      tick();
      m_bus.abort = 1'b0;

      // Abort beats start and halt; count held, then cleared by a new start
      start_run(1'b0, 32'd0);
      reached = 0;
      for (int c = 0; c < 30; c++) begin
         if (m_bus.cycle_count == 32'd7) begin
            reached = 1;
            break;
         end
         tick();
      end
      check_output("t5.reached", 32'(reached), 32'd1);
      m_bus.abort = 1'b1; m_bus.start = 1'b1; m_bus.core_halt = 2'b11;
      tick();
      m_bus.abort = 1'b0; m_bus.start = 1'b0; m_bus.core_halt = 2'b00;
      check_output("t5.core_reset", 32'(m_bus.core_reset), 32'h3);
      check_output("t5.busy", 32'(m_bus.busy), 32'd0);
      check_output("t5.done", 32'(m_bus.done), 32'd0);
      check_output("t5.halted", 32'(m_bus.halted), 32'h0);
      tick();
      check_output("t5.cycle_count", m_bus.cycle_count, 32'd7);
      start_run(1'b0, 32'd0);
      check_output("t5.restart_count", m_bus.cycle_count, 32'd0);
      check_output("t5.restart_busy", 32'(m_bus.busy), 32'd1);

      // Saturation on the narrow counter, then async reset mid-run
      s_bus.start = 1'b1;
      tick();
      s_bus.start = 1'b0;
      for (int c = 0; c < 22; c++) tick();
      check_output("t6.sat_count", 32'(s_bus.cycle_count), 32'hF);
      check_output("t6.sat_busy", 32'(s_bus.busy), 32'd1);
      check_output("t6.sat_en", 32'(s_bus.core_en), 32'h1);
      check_output("t6.main_en", 32'(m_bus.core_en), 32'h3);
      #2 reset = 1'b0;
      #1;
      check_output("t6.ar_sat_reset", 32'(s_bus.core_reset), 32'h1);
      check_output("t6.ar_sat_en", 32'(s_bus.core_en), 32'h0);
      check_output("t6.ar_sat_busy", 32'(s_bus.busy), 32'd0);
      check_output("t6.ar_sat_count", 32'(s_bus.cycle_count), 32'h0);
      check_output("t6.ar_main_reset", 32'(m_bus.core_reset), 32'h3);
      check_output("t6.ar_main_en", 32'(m_bus.core_en), 32'h0);
      check_output("t6.ar_main_busy", 32'(m_bus.busy), 32'd0);
      check_output("t6.ar_main_done", 32'(m_bus.done), 32'd0);
      check_output("t6.ar_main_timeout", 32'(m_bus.timeout), 32'd0);
      check_output("t6.ar_main_halted", 32'(m_bus.halted), 32'h0);
      check_output("t6.ar_main_count", m_bus.cycle_count, 32'h0);
      @(negedge ref_clk);
      reset = 1'b1;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/proc_run_ctrl.md
Name: proc_run_ctrl

Overview:
Synthesizable run controller that sequences reset, execution and termination for one or more MIPS processor cores. It turns the bench-style "hold reset 2 cycles, run a fixed time, stop" sequence into parametrised hardware. Features: programmable reset stretch, cycle budget with timeout, per-core halt tracking, single-step mode and abort. It sits between the top-level clock/reset and each processor's reset/clock-enable inputs.

Parameters:
N_CORES, 1, number of controlled cores (per-core reset/enable/halt lanes)
RST_CYCLES, 2, cycles core_reset is held high after start is accepted (>=1)
CNT_W, 32, width of cycle counter and max_cycles

Ports:
ref_clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low (reset=0 asserts); controller reset
start  in  1  single-cycle pulse: begin a run (accepted in IDLE or DONE only)
abort  in  1  force return to IDLE from any state
step_mode  in  1  sampled with start; 1 = single-step run
step  in  1  in step mode, one pulse grants one enabled cycle
max_cycles  in  CNT_W  cycle budget, sampled with start; 0 = unlimited
core_halt  in  N_CORES  per-core halt indication (e.g. halt/break decoded)
core_reset  out  N_CORES  active-high reset to each core
core_en  out  N_CORES  per-core clock enable
busy  out  1  high in RST_HOLD or RUN
done  out  1  high in DONE
timeout  out  1  DONE reached because budget exhausted
halted  out  N_CORES  sticky per-core halted flags
cycle_count  out  CNT_W  enabled cycles executed this run

Behaviour:
- Reset (reset=0, async): state IDLE; core_reset all 1; core_en 0; busy 0; done 0; timeout 0; halted 0; cycle_count 0; hold counter 0.
- States: IDLE, RST_HOLD, RUN, DONE. All outputs registered.
- IDLE: core_reset=all 1, core_en=0. start=1 -> RST_HOLD next cycle; latch step_mode, max_cycles; clear cycle_count, halted, timeout.
- RST_HOLD: core_reset=all 1 for exactly RST_CYCLES cycles, counted from first RST_HOLD cycle, then RUN. core_en=0.
- RUN: core_reset=0. core_en[i]=1 when lane not halted and (step_mode=0, or step sampled high the previous cycle). Step pulses while a granted cycle is in flight are not queued.
- cycle_count increments by 1 on each cycle any core_en bit is 1; saturates at all-ones, no wrap.
- halted[i] sets on any cycle core_en[i]=1 and core_halt[i]=1. Sticky until next start. core_en[i] drops the following cycle; other lanes continue. core_halt on a disabled lane is ignored.
- All lanes halted -> DONE next cycle, timeout=0.
- max_cycles!=0 and cycle_count reaches max_cycles (after increment) with lanes still running -> DONE, timeout=1.
- Halt and budget exhaustion on the same cycle -> halt wins, timeout=0.
- DONE: core_en=0, core_reset=0 so core state can be inspected. done=1; cycle_count, halted, timeout held. start -> RST_HOLD as from IDLE.
- start during RST_HOLD or RUN: ignored.
- abort=1 in any state -> IDLE next cycle, core_reset=1, done=0, timeout=0. cycle_count and halted are held until the next start. abort has priority over start and halt on the same cycle.
- Async reset asserted mid-run: immediate return to reset values, no partial state retained.
- core_halt is assumed synchronous to ref_clk. No synchronizers inside.

Test Plan:
1. N_CORES=1, RST_CYCLES=2, max_cycles=36, halt never asserted; pulse start -> core_reset high 2 cycles, core_en high 36 cycles, then done=1, timeout=1, cycle_count=36.
2. N_CORES=2, max_cycles=0. Halt lane0 at enabled cycle 5, lane1 at cycle 9 -> halted=2'b01 after cycle 5; core_en[0] low from cycle 6. done=1, timeout=0, halted=2'b11, cycle_count=9.
3. step_mode=1. After RST_HOLD, three step pulses spaced 4 cycles apart -> exactly three single-cycle core_en pulses, cycle_count=3, busy=1, done=0.
4. max_cycles=10, lane halts on enabled cycle 10 -> done=1, timeout=0, cycle_count=10 (halt wins tie).
5. abort at RUN cycle 7 with start also high -> IDLE next cycle, core_reset=1, done=0, cycle_count=7 held. A later start clears count and re-enters RST_HOLD.
6. CNT_W=4, max_cycles=0, no halt for 20 cycles -> cycle_count saturates at 15, still RUN. Assert reset=0 mid-run -> all outputs immediately at reset values.
